freq_gate_counter: RTL and testbench

Frequency-measurement front end that feeds the multiplexed seven-segment display driver.
- Synchronises an external `freq_in` signal into `sys_clk` and counts its rising edges over a fixed gate window.
- At the end of each window, latches the count as binary, then converts it to 8 packed BCD digits with a serial double-dabble engine.
- Pulses `data_valid` so the display driver can take the new value.

---
 rtl/freq_gate_counter.sv | 199 +++++++++++++++++++
 tb/tb_freq_gate_counter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of an asynchronous input over a fixed
// gate window of GATE_CYCLES sys_clk cycles and latches the saturated total.
// Optional feature macro FREQ_BCD_EN: when defined, a serial double-dabble
// engine converts each total into 8 packed BCD digits before data_valid pulses.
// When undefined, freq_bcd and busy are tied to 0 and data_valid pulses in the
// cycle right after the gate window ends.
// data_valid is a one-cycle strobe with no back-pressure: the consumer must take
// freq_bin / freq_bcd / ovf in the cycle it is high (they then hold until the
// next strobe).
module freq_gate_counter #(
  parameter int GATE_CYCLES = 48_000_000,
  parameter int MAX_COUNT   = 99_999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        freq_in,
  output logic [26:0] freq_bin,
  output logic [31:0] freq_bcd,
  output logic        ovf,
  output logic        data_valid,
  output logic        busy
);

  localparam int            GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [26:0]   MAX_C     = 27'(MAX_COUNT);

  // Synchroniser, edge detector and counters
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [GW-1:0] gate_cnt_q, gate_cnt_d;
  logic [26:0]   edge_cnt_q, edge_cnt_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic [26:0]   freq_bin_q, freq_bin_d;
  logic          ovf_q, ovf_d;
  logic          data_valid_q, data_valid_d;

  logic          edge_det;
  logic          gate_end;
  logic          at_max;
  logic [26:0]   win_total;
  logic          win_ovf;

  // Edge detection, gate timing and the saturating window total
  always_comb begin
    s1_d       = freq_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    edge_det   = s2_q & ~s3_q;
    gate_end   = (gate_cnt_q == GATE_LAST);
    gate_cnt_d = gate_end ? '0 : gate_cnt_q + GW'(1);
    at_max     = (edge_cnt_q >= MAX_C);
    // An edge in the gate_end cycle is folded into the ending window here.
    win_total  = (edge_det && !at_max) ? edge_cnt_q + 27'd1 : edge_cnt_q;
    win_ovf    = ovf_flag_q | (edge_det & at_max);
    freq_bin_d = freq_bin_q;
    ovf_d      = ovf_q;
    if (gate_end) begin
      edge_cnt_d = '0;
      ovf_flag_d = 1'b0;
      freq_bin_d = win_total;
      ovf_d      = win_ovf;
    end else begin
      edge_cnt_d = win_total;
      ovf_flag_d = win_ovf;
    end
  end

  // Front-end registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_flag_q <= 1'b0;
      freq_bin_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_flag_q <= ovf_flag_d;
      freq_bin_q <= freq_bin_d;
      ovf_q      <= ovf_d;
    end
  end

  assign freq_bin   = freq_bin_q;
  assign ovf        = ovf_q;
  assign data_valid = data_valid_q;

`ifdef FREQ_BCD_EN

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] N_BITS = 5'd27;

  state_t      state_q, state_d;
  logic [26:0] shift_q, shift_d;
  logic [31:0] acc_q, acc_d, acc_adj;
  logic [4:0]  iter_q, iter_d;
  logic [31:0] freq_bcd_q, freq_bcd_d;
  logic        busy_q, busy_d;

  // Double-dabble sequencing; outputs are set one cycle early so they are
  // registered and appear exactly in the DONE cycle.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 8; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    state_d      = state_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    iter_d       = iter_q;
    freq_bcd_d   = freq_bcd_q;
    busy_d       = busy_q;
    data_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gate_end) begin
          state_d = ST_SHIFT;
          shift_d = win_total;
          acc_d   = '0;
          iter_d  = N_BITS;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        acc_d   = {acc_adj[30:0], shift_q[26]};
        shift_d = {shift_q[25:0], 1'b0};
        iter_d  = iter_q - 5'd1;
        if (iter_q == 5'd1) begin
          state_d      = ST_DONE;
          freq_bcd_d   = {acc_adj[30:0], shift_q[26]};
          data_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // BCD FSM state and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      acc_q        <= '0;
      iter_q       <= '0;
      freq_bcd_q   <= '0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      iter_q       <= iter_d;
      freq_bcd_q   <= freq_bcd_d;
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign freq_bcd = freq_bcd_q;
  assign busy     = busy_q;

`else

  // Without conversion the strobe follows gate_end by one cycle
  always_comb begin
    data_valid_d = gate_end;
  end

  // Strobe register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) data_valid_q <= 1'b0;
    else            data_valid_q <= data_valid_d;
  end

  assign freq_bcd = '0;
  assign busy     = 1'b0;

`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: two instances share clock, reset and input
// (GATE_CYCLES=100, one with default MAX_COUNT, one with MAX_COUNT=5).
module tb_freq_gate_counter;

  localparam int G    = 100;
  localparam int MAX0 = 99_999_999;
  localparam int MAX1 = 5;
`ifdef FREQ_BCD_EN
  localparam int DV_LAT = 28;
  localparam bit BCD_ON = 1'b1;
`else
  localparam int DV_LAT = 1;
  localparam bit BCD_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        freq_in;
  logic [26:0] bin0, bin1;
  logic [31:0] bcd0, bcd1;
  logic        ovf0, ovf1, dv0, dv1, busy0, busy1;

  always #5 sys_clk = ~sys_clk;

  freq_gate_counter #(.GATE_CYCLES(G), .MAX_COUNT(MAX0)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .freq_in(freq_in),
    .freq_bin(bin0), .freq_bcd(bcd0), .ovf(ovf0), .data_valid(dv0), .busy(busy0));

  freq_gate_counter #(.GATE_CYCLES(G), .MAX_COUNT(MAX1)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .freq_in(freq_in),
    .freq_bin(bin1), .freq_bcd(bcd1), .ovf(ovf1), .data_valid(dv1), .busy(busy1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [26:0] sat_of(input int tot, input int mx);
    return (tot > mx) ? 27'(mx) : 27'(tot);
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // hist holds freq_in as seen at the last three rising clock edges
  bit hist[$];
  int win_cnt, pend_tot, m_tot, m_bcd_tot, bin_due, dv_due, last_t;
  bit m_dv, m_busy;

  task automatic model_reset();
    cyc = 0;
    hist = '{1'b0, 1'b0, 1'b0};
    win_cnt = 0; pend_tot = 0; m_tot = 0; m_bcd_tot = 0;
    bin_due = -1; dv_due = -1; last_t = -1;
    m_dv = 1'b0; m_busy = 1'b0;
  endtask

  task automatic mon_chk(input string tag, input int mx, input logic [26:0] b, input logic o,
                         input logic [31:0] bcd, input logic dvv, input logic bsy);
    chk({tag, ".freq_bin"},   32'(b),   32'(sat_of(m_tot, mx)));
    chk({tag, ".ovf"},        32'(o),   32'(m_tot > mx));
    chk({tag, ".freq_bcd"},   bcd,      BCD_ON ? to_bcd(int'(sat_of(m_bcd_tot, mx))) : 32'h0);
    chk({tag, ".data_valid"}, 32'(dvv), 32'(m_dv));
    chk({tag, ".busy"},       32'(bsy), 32'(m_busy));
  endtask

  // Cycle-by-cycle monitor: rising edges of the sampled input are counted in
  // the window of the cycle two edges later.
  always @(posedge sys_clk) begin
    if (sys_rst_n) begin
      cyc++;
      hist.push_back(freq_in);
      hist.delete(0);
    end
    #2;
    if (!sys_rst_n) begin
      model_reset();
    end else begin
      if (cyc == bin_due) m_tot = pend_tot;
      if (cyc == dv_due) begin
        m_dv = 1'b1;
        m_bcd_tot = pend_tot;
      end else begin
        m_dv = 1'b0;
      end
      m_busy = BCD_ON && (last_t >= 0) && (cyc - last_t >= 1) && (cyc - last_t <= 28);
    end
    mon_chk("mon0", MAX0, bin0, ovf0, bcd0, dv0, busy0);
    mon_chk("mon1", MAX1, bin1, ovf1, bcd1, dv1, busy1);
    if (sys_rst_n) begin
      if (hist[1] && !hist[0]) win_cnt++;
      if (cyc % G == G - 1) begin
        pend_tot = win_cnt;
        win_cnt  = 0;
        last_t   = cyc;
        bin_due  = cyc + 1;
        dv_due   = cyc + DV_LAT;
      end
    end
  end

  // ---------------- input driver ----------------
  int drv_mode = 0;   // 0 manual, 1 periodic, 2 random
  int drv_hi, drv_lo, drv_ph, rnd_left;

  // Waveform generator for freq_in, updated on falling edges
  always @(negedge sys_clk) begin
    if (drv_mode == 1) begin
      freq_in = (drv_ph < drv_hi);
      drv_ph  = (drv_ph + 1 >= drv_hi + drv_lo) ? 0 : drv_ph + 1;
    end else if (drv_mode == 2) begin
      if (rnd_left <= 1) begin
        freq_in  = ~freq_in;
        rnd_left = $urandom_range(2, 7);
      end else begin
        rnd_left--;
      end
    end
  end

  task automatic wait_dv(output int at_cyc);
    int n;
    n = 0;
    at_cyc = -1;
    while (n < 3 * G) begin
      @(negedge sys_clk);
      if (dv0) begin
        at_cyc = cyc;
        break;
      end
      n++;
    end
    if (at_cyc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dv_timeout @cyc %0d: got no data_valid expected one within %0d cycles", cyc, 3 * G);
    end
  endtask

  task automatic wait_until(input int x);
    int n;
    n = 0;
    while (cyc < x && n < 4 * G) begin
      @(negedge sys_clk);
      n++;
    end
    if (cyc < x) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_cycle_timeout: got cyc %0d expected %0d", cyc, x);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".bin0"},  32'(bin0),  32'h0);
    chk({tag, ".bcd0"},  bcd0,       32'h0);
    chk({tag, ".ovf1"},  32'(ovf1),  32'h0);
    chk({tag, ".bin1"},  32'(bin1),  32'h0);
    chk({tag, ".dv0"},   32'(dv0),   32'h0);
    chk({tag, ".busy0"}, 32'(busy0), 32'h0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          hi;
    int          lo;
    int          exp_bin;
    logic [31:0] exp_bcd;
    int          exp_bin_s;
    bit          exp_ovf_s;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  int at, t_end, dv_seen;

  // Main test sequence
  initial begin
    vecs[0] = '{5,  5,  10, 32'h10, 5, 1'b1};
    vecs[1] = '{0,  0,  0,  32'h0,  0, 1'b0};   // held low after a saturated window
    vecs[2] = '{2,  2,  25, 32'h25, 5, 1'b1};
    vecs[3] = '{2,  3,  20, 32'h20, 5, 1'b1};
    vecs[4] = '{10, 10, 5,  32'h5,  5, 1'b0};   // exactly MAX_COUNT edges
    vecs[5] = '{12, 13, 4,  32'h4,  4, 1'b0};
    vecs[6] = '{25, 25, 2,  32'h2,  2, 1'b0};
    vecs[7] = '{50, 50, 1,  32'h1,  1, 1'b0};

    sys_rst_n = 1'b0;
    freq_in   = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_zero_outputs("reset_state");
    sys_rst_n = 1'b1;

    // first strobe after release
    wait_dv(at);
    chk("first_dv_cycle", 32'(at), 32'(G - 1 + DV_LAT));
    chk("first_bin_idle", 32'(bin0), 32'h0);

    // table of steady periodic inputs; the third strobe covers a fully steady window
    for (int k = 0; k < NV; k++) begin
      if (vecs[k].hi == 0) begin
        drv_mode = 0;
        freq_in  = 1'b0;
      end else begin
        drv_hi   = vecs[k].hi;
        drv_lo   = vecs[k].lo;
        drv_ph   = 0;
        drv_mode = 1;
      end
      repeat (3) wait_dv(at);
      chk($sformatf("vec%0d.freq_bin", k),   32'(bin0), 32'(vecs[k].exp_bin));
      chk($sformatf("vec%0d.freq_bcd", k),   bcd0,      BCD_ON ? vecs[k].exp_bcd : 32'h0);
      chk($sformatf("vec%0d.ovf", k),        32'(ovf0), 32'h0);
      chk($sformatf("vec%0d.sat_bin", k),    32'(bin1), 32'(vecs[k].exp_bin_s));
      chk($sformatf("vec%0d.sat_ovf", k),    32'(ovf1), 32'(vecs[k].exp_ovf_s));
    end

    // reset asserted mid-window clears outputs at once
    repeat (20) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk_zero_outputs("rst_async");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_dv(at);
    chk("rst_first_dv_cycle", 32'(at), 32'(G - 1 + DV_LAT));

    // four edges, the last one detected exactly in the gate_end cycle
    drv_mode = 0;
    freq_in  = 1'b0;
    wait_dv(at);
    t_end = cyc + (G - 1 - cyc % G);
    if (t_end < cyc + 35) t_end += G;
    for (int j = 3; j >= 1; j--) begin
      wait_until(t_end - 10 * j - 2);
      freq_in = 1'b1;
      wait_until(t_end - 10 * j + 2);
      freq_in = 1'b0;
    end
    wait_until(t_end - 2);
    freq_in = 1'b1;
    wait_dv(at);
    chk("gate_edge.dv_latency", 32'(at - t_end), 32'(DV_LAT));
    chk("gate_edge.freq_bin",   32'(bin0), 32'd4);
    chk("gate_edge.freq_bcd",   bcd0,      BCD_ON ? 32'h4 : 32'h0);
    chk("gate_edge.sat_bin",    32'(bin1), 32'd4);
    chk("gate_edge.sat_ovf",    32'(ovf1), 32'h0);
    freq_in = 1'b0;
    wait_dv(at);
    chk("gate_edge.next_bin",   32'(bin0), 32'h0);

    // reset pulse ten cycles into the conversion
    drv_hi = 5; drv_lo = 5; drv_ph = 0; drv_mode = 1;
    wait_dv(at);
    t_end = cyc + (G - 1 - cyc % G);
    wait_until(t_end + 10);
    chk("abort.busy_before", 32'(busy0), 32'(BCD_ON));
    sys_rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    dv_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge sys_clk);
      if (dv0 || dv1) dv_seen++;
    end
    chk("abort.no_dv", 32'(dv_seen), 32'h0);

    // randomized input, checked cycle by cycle by the monitor
    rnd_left = 1;
    drv_mode = 2;
    repeat (20) wait_dv(at);
    drv_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Overall time limit
  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
